// File: rtl/vga_pattern_source.sv
// Pixel-data stage behind the VGA timing generator: tracks active-area position and
// emits a switch-selected 12-bit test pattern, with syncs delayed to match RGB latency.
module vga_pattern_source #(
  parameter int unsigned HD        = 1280,
  parameter int unsigned VD        = 1024,
  parameter int unsigned X_BITS    = 11,
  parameter int unsigned Y_BITS    = 11,
  parameter int unsigned BOX_SIZE  = 64,
  parameter int unsigned CHECK_BIT = 5
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        PixelEnIn,
  input  logic        HsyncIn,
  input  logic        VsyncIn,
  input  logic [1:0]  Mode,
  input  logic [11:0] SwColor,
  output logic        HsyncOut,
  output logic        VsyncOut,
  output logic [11:0] RGB,
  output logic [7:0]  FrameCount
);

  localparam logic [X_BITS-1:0] XLast = X_BITS'(HD - 1);
  localparam logic [Y_BITS-1:0] YLast = Y_BITS'(VD - 1);
  localparam logic [X_BITS-1:0] CLast = X_BITS'(HD / 8 - 1);
  localparam logic [X_BITS-1:0] BxMax = X_BITS'(HD - BOX_SIZE);
  localparam logic [Y_BITS-1:0] ByMax = Y_BITS'(VD - BOX_SIZE);
  localparam logic [X_BITS:0]   BoxW  = (X_BITS + 1)'(BOX_SIZE);
  localparam logic [Y_BITS:0]   BoxH  = (Y_BITS + 1)'(BOX_SIZE);

  logic              vsync_q;
  logic [X_BITS-1:0] x_q, x_d, c_q, c_d, bx_q, bx_d;
  logic [Y_BITS-1:0] y_q, y_d, by_q, by_d;
  logic [2:0]        b_q, b_d;
  logic [1:0]        mode_q;
  logic              dx_q, dx_d, dy_q, dy_d;  // 1 = moving in the + direction
  logic [7:0]        frame_q;
  logic [11:0]       rgb_q, rgb_d, pix, bar_rgb;
  logic              hs_q, vs_q;
  logic              fs, in_box;

  assign fs = VsyncIn & ~vsync_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    b_d = b_q;
    c_d = c_q;
    if (fs) begin
      x_d = '0;
      y_d = '0;
      b_d = '0;
      c_d = '0;
    end else if (PixelEnIn) begin
      if (x_q == XLast) begin
        x_d = '0;
        y_d = (y_q == YLast) ? '0 : y_q + Y_BITS'(1);
        b_d = '0;
        c_d = '0;
      end else begin
        x_d = x_q + X_BITS'(1);
        if (c_q == CLast) begin
          c_d = '0;
          b_d = b_q + 3'd1;
        end else begin
          c_d = c_q + X_BITS'(1);
        end
      end
    end
  end

  // Box bounces off the edges, stepping once per frame.
  always_comb begin
    bx_d = bx_q;
    by_d = by_q;
    dx_d = dx_q;
    dy_d = dy_q;
    if (fs) begin
      if (dx_q && bx_q == BxMax) begin
        dx_d = 1'b0;
        bx_d = bx_q - X_BITS'(1);
      end else if (!dx_q && bx_q == '0) begin
        dx_d = 1'b1;
        bx_d = X_BITS'(1);
      end else begin
        bx_d = dx_q ? bx_q + X_BITS'(1) : bx_q - X_BITS'(1);
      end
      if (dy_q && by_q == ByMax) begin
        dy_d = 1'b0;
        by_d = by_q - Y_BITS'(1);
      end else if (!dy_q && by_q == '0) begin
        dy_d = 1'b1;
        by_d = Y_BITS'(1);
      end else begin
        by_d = dy_q ? by_q + Y_BITS'(1) : by_q - Y_BITS'(1);
      end
    end
  end

  always_comb begin
    bar_rgb = 12'h000;
    case (b_q)
      3'd0:    bar_rgb = 12'hFFF;
      3'd1:    bar_rgb = 12'hFF0;
      3'd2:    bar_rgb = 12'h0FF;
      3'd3:    bar_rgb = 12'h0F0;
      3'd4:    bar_rgb = 12'hF0F;
      3'd5:    bar_rgb = 12'hF00;
      3'd6:    bar_rgb = 12'h00F;
      default: bar_rgb = 12'h000;
    endcase
  end

  assign in_box = ({1'b0, x_q} >= {1'b0, bx_q}) && ({1'b0, x_q} < {1'b0, bx_q} + BoxW) &&
                  ({1'b0, y_q} >= {1'b0, by_q}) && ({1'b0, y_q} < {1'b0, by_q} + BoxH);

  always_comb begin
    pix = SwColor;
    unique case (mode_q)
      2'd0: pix = SwColor;
      2'd1: pix = bar_rgb;
      2'd2: pix = (x_q[CHECK_BIT] ^ y_q[CHECK_BIT]) ? SwColor : 12'h000;
      2'd3: pix = in_box ? SwColor : 12'h222;
    endcase
    rgb_d = PixelEnIn ? pix : 12'h000;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vsync_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      mode_q  <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      frame_q <= '0;
      rgb_q   <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      vsync_q <= VsyncIn;
      x_q     <= x_d;
      y_q     <= y_d;
      b_q     <= b_d;
      c_q     <= c_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      rgb_q   <= rgb_d;
      hs_q    <= HsyncIn;
      vs_q    <= VsyncIn;
      if (fs) begin
        mode_q  <= Mode;
        frame_q <= frame_q + 8'd1;
      end
    end
  end

  assign RGB        = rgb_q;
  assign HsyncOut   = hs_q;
  assign VsyncOut   = vs_q;
  assign FrameCount = frame_q;

endmodule

// File: tb/tb_vga_pattern_source.sv
// Bench for vga_pattern_source: full-size instance for solid/bars/checker/frame count,
// small instance for the bouncing box and asynchronous reset.
module tb_vga_pattern_source;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        PixelEnIn = 1'b0;
  logic        HsyncIn = 1'b0;
  logic        VsyncIn = 1'b0;
  logic [1:0]  Mode = 2'd0;
  logic [11:0] SwColor = 12'h000;
  logic        HsyncOut, VsyncOut, s_hs, s_vs;
  logic [11:0] RGB, s_rgb;
  logic [7:0]  FrameCount, s_fc;

  always #5 Clk = ~Clk;

  vga_pattern_source dut (
    .Clk(Clk), .Reset_n(Reset_n), .PixelEnIn(PixelEnIn), .HsyncIn(HsyncIn),
    .VsyncIn(VsyncIn), .Mode(Mode), .SwColor(SwColor), .HsyncOut(HsyncOut),
    .VsyncOut(VsyncOut), .RGB(RGB), .FrameCount(FrameCount)
  );

  vga_pattern_source #(
    .HD(16), .VD(12), .X_BITS(4), .Y_BITS(4), .BOX_SIZE(4), .CHECK_BIT(2)
  ) dut_s (
    .Clk(Clk), .Reset_n(Reset_n), .PixelEnIn(PixelEnIn), .HsyncIn(HsyncIn),
    .VsyncIn(VsyncIn), .Mode(Mode), .SwColor(SwColor), .HsyncOut(s_hs),
    .VsyncOut(s_vs), .RGB(s_rgb), .FrameCount(s_fc)
  );

  typedef struct packed {
    logic        sel;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  typedef struct packed {
    logic        en;
    logic        hs;
    logic        vs;
    logic [1:0]  mode;
    logic [11:0] sw;
    logic [11:0] exp_rgb;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[11];
  logic [11:0] bars[8];
  int          n_vec = 0;
  int          n_err = 0;
  int          fs_cnt = 0;
  logic        vs_prev = 1'b0;
  logic [1:0]  nxt_mode = 2'd0;
  logic [11:0] nxt_sw = 12'h000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_check();
    exp_t        e;
    logic [13:0] act;
    if (sb.size() == 0) return;
    e   = sb.pop_front();
    act = e.sel ? {s_rgb, s_hs, s_vs} : {RGB, HsyncOut, VsyncOut};
    check(e.sel ? "small {rgb,hs,vs}" : "{rgb,hs,vs}", 32'(act), 32'({e.rgb, e.hs, e.vs}));
  endtask

  // One pixel clock: check the output due now, then drive and queue the next expectation.
  task automatic cyc(input logic en, input logic hs, input logic vs, input logic sel,
                     input logic [11:0] exp_rgb);
    exp_t e;
    @(negedge Clk);
    pop_check();
    PixelEnIn = en;
    HsyncIn   = hs;
    VsyncIn   = vs;
    Mode      = nxt_mode;
    SwColor   = nxt_sw;
    if (vs && !vs_prev) fs_cnt++;
    vs_prev = vs;
    e.sel = sel;
    e.rgb = en ? exp_rgb : 12'h000;
    e.hs  = hs;
    e.vs  = vs;
    sb.push_back(e);
  endtask

  function automatic int tri_pos(input int k, input int span);
    int p;
    p = k % (2 * span);
    return (p <= span) ? p : 2 * span - p;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    //          en    hs    vs    mode  sw       exp
    vecs[0]  = {1'b0, 1'b1, 1'b0, 2'd0, 12'hABC, 12'h000};
    vecs[1]  = {1'b1, 1'b0, 1'b0, 2'd0, 12'hABC, 12'hABC};
    vecs[2]  = {1'b1, 1'b0, 1'b0, 2'd0, 12'h5A3, 12'h5A3};
    vecs[3]  = {1'b0, 1'b0, 1'b0, 2'd0, 12'h5A3, 12'h000};
    vecs[4]  = {1'b1, 1'b0, 1'b0, 2'd1, 12'h123, 12'h123};  // mode switch ignored mid-frame
    vecs[5]  = {1'b1, 1'b1, 1'b0, 2'd1, 12'hFFF, 12'hFFF};
    vecs[6]  = {1'b0, 1'b0, 1'b1, 2'd1, 12'h5A3, 12'h000};  // frame start loads mode 1
    vecs[7]  = {1'b1, 1'b0, 1'b1, 2'd0, 12'h5A3, 12'hFFF};  // bar 0 from x=0 after resync
    vecs[8]  = {1'b1, 1'b0, 1'b1, 2'd0, 12'h5A3, 12'hFFF};
    vecs[9]  = {1'b0, 1'b0, 1'b0, 2'd0, 12'h5A3, 12'h000};
    vecs[10] = {1'b1, 1'b0, 1'b0, 2'd0, 12'h5A3, 12'hFFF};

    // Reset held with active inputs.
    Reset_n   = 1'b0;
    PixelEnIn = 1'b1;
    HsyncIn   = 1'b1;
    SwColor   = 12'hABC;
    repeat (3) @(negedge Clk);
    check("reset rgb", 32'(RGB), 32'h0);
    check("reset framecount", 32'(FrameCount), 32'h0);
    check("reset hsyncout", 32'(HsyncOut), 32'h0);
    check("reset vsyncout", 32'(VsyncOut), 32'h0);
    PixelEnIn = 1'b0;
    HsyncIn   = 1'b0;
    Reset_n   = 1'b1;

    foreach (vecs[i]) begin
      nxt_mode = vecs[i].mode;
      nxt_sw   = vecs[i].sw;
      cyc(vecs[i].en, vecs[i].hs, vecs[i].vs, 1'b0, vecs[i].exp_rgb);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    check("framecount after first fs", 32'(FrameCount), 32'(8'(fs_cnt)));

    // Colour bars: one full line, blanking, then the start of the next line.
    nxt_mode = 2'd1;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    for (int x = 0; x < 1280; x++) cyc(1'b1, 1'b0, 1'b0, 1'b0, bars[x / 160]);
    repeat (4) cyc(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    for (int x = 0; x < 200; x++) cyc(1'b1, 1'b0, 1'b0, 1'b0, bars[x / 160]);

    // Checkerboard through line 32, continuous enable across line wraps.
    nxt_mode = 2'd2;
    nxt_sw   = 12'hF00;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    for (int y = 0; y <= 32; y++) begin
      for (int x = 0; x < ((y == 32) ? 41 : 1280); x++) begin
        cyc(1'b1, 1'b0, 1'b0, 1'b0, ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 12'hF00 : 12'h000);
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    check("framecount before long vsync", 32'(FrameCount), 32'(8'(fs_cnt)));

    // Long VsyncIn pulse counts once; then run the counter through its wrap.
    repeat (40) cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    check("framecount long vsync", 32'(FrameCount), 32'h4);
    while (fs_cnt < 256) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
      if (fs_cnt == 255) check("framecount 255", 32'(FrameCount), 32'hFF);
    end
    check("framecount wrap", 32'(FrameCount), 32'h0);

    // Bouncing box on the small instance.
    @(negedge Clk);
    pop_check();
    Reset_n = 1'b0;
    PixelEnIn = 1'b0;
    VsyncIn = 1'b0;
    HsyncIn = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    vs_prev = 1'b0;
    fs_cnt  = 0;
    nxt_mode = 2'd3;
    nxt_sw   = 12'h0F0;
    for (int k = 1; k <= 26; k++) begin
      int bxe, bye;
      bxe = tri_pos(k, 12);
      bye = tri_pos(k, 8);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
      for (int y = 0; y < 12; y++) begin
        for (int x = 0; x < 16; x++) begin
          cyc(1'b1, 1'b0, 1'b0, 1'b1,
              (x >= bxe && x < bxe + 4 && y >= bye && y < bye + 4) ? 12'h0F0 : 12'h222);
        end
      end
    end
    check("small framecount", 32'(s_fc), 32'd26);

    // Asynchronous reset mid-frame, then solid colour until the next frame start.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 12'h222);
    @(posedge Clk);
    #2;
    sb.delete();
    check("small rgb before async reset", 32'(s_rgb), 32'h222);
    Reset_n = 1'b0;
    #1;
    check("small rgb async reset", 32'(s_rgb), 32'h0);
    check("small framecount async reset", 32'(s_fc), 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    vs_prev = 1'b0;
    fs_cnt  = 0;
    nxt_sw  = 12'h3C5;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 12'h3C5);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 12'h3C5);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
